// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the AES core scheduling logic.
package aes_ctrl_pkg;

  localparam int unsigned AES_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    int unsigned cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(last_grant) + 32'd1 + i) % NUM_REQ;
      if (!any && req[IDX_W'(cand)]) begin
        grant[IDX_W'(cand)] = 1'b1;
        grant_idx           = IDX_W'(cand);
        any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one iterative AES core between NUM_REQ requesters, one job at a time,
// with round-robin grants and a finish timeout that returns an error response.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_dec,
  input  logic [NUM_REQ*AES_W-1:0] req_plain,
  input  logic [NUM_REQ*AES_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [AES_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic [AES_W-1:0]         core_plain,
  output logic [AES_W-1:0]         core_key,
  output logic                     core_dec,
  output logic                     core_start,
  input  logic                     core_finish,
  input  logic [AES_W-1:0]         core_cipher,
  output logic                     busy
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  state_e               state;
  state_e               state_nxt;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     arb_idx;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_any;
  logic [TIMER_W-1:0]   timer;
  logic                 timeout_hit;
  logic                 accept;
  logic                 resp_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Timer counts from the start pulse, so the abort lands TIMEOUT cycles after it.
  assign timeout_hit = (timer >= TIMER_W'(TIMEOUT - 1));
  assign accept      = (state == S_IDLE) && arb_any;
  assign resp_hs     = (state == S_RESP) && resp_ready[owner];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; finish takes precedence over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (core_finish || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (resp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant is only offered in IDLE and is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    busy      = (state != S_IDLE);
    if (state == S_IDLE && !rst) req_ready = arb_grant;
  end

  // Job operands, owner tracking, timer and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_plain <= '0;
      core_key   <= '0;
      core_dec   <= 1'b0;
      core_start <= 1'b0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      timer      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      core_start <= accept;

      if (accept) begin
        core_plain <= req_plain[AES_W*arb_idx +: AES_W];
        core_key   <= req_key[AES_W*arb_idx +: AES_W];
        core_dec   <= req_dec[arb_idx];
        owner      <= arb_idx;
        last_grant <= arb_idx;
        timer      <= '0;
      end else if (state == S_ISSUE || state == S_WAIT) begin
        timer <= timer + TIMER_W'(1);
      end

      if (state == S_WAIT) begin
        if (core_finish) begin
          resp_data  <= core_cipher;
          resp_err   <= 1'b0;
          resp_valid <= NUM_REQ'(1) << owner;
        end else if (timeout_hit) begin
          resp_data  <= '0;
          resp_err   <= 1'b1;
          resp_valid <= NUM_REQ'(1) << owner;
        end
      end else if (resp_hs) begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter with a behavioural core and scheduler model.
module tb_aes_core_arbiter;

  localparam int NR      = 2;
  localparam int TMO     = 64;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_dec;
  logic [NR*128-1:0] req_plain;
  logic [NR*128-1:0] req_key;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [127:0]      resp_data;
  logic              resp_err;
  logic [127:0]      core_plain;
  logic [127:0]      core_key;
  logic              core_dec;
  logic              core_start;
  logic              core_finish;
  logic [127:0]      core_cipher;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int last_g;
  logic [127:0] plain_v [NR];
  logic [127:0] key_v   [NR];
  logic         dec_v   [NR];

  aes_core_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec),
    .req_plain(req_plain), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .core_plain(core_plain), .core_key(core_key), .core_dec(core_dec),
    .core_start(core_start), .core_finish(core_finish), .core_cipher(core_cipher),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in for the AES core: FIPS-197 vector both ways, otherwise a keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k, input logic d);
    if (!d && k == FIPS_K && p == FIPS_P) return FIPS_C;
    if (d && k == FIPS_K && p == FIPS_C) return FIPS_P;
    return {p[63:0], p[127:64]} ^ k ^ {128{d}};
  endfunction

  // Reference round-robin: first valid requester after the previous grant.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    int pick = -1;
    for (int i = 1; i <= NR; i++) begin
      int c = (last + i) % NR;
      if (pick < 0 && v[c]) pick = c;
    end
    return pick;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_plain[128*i +: 128] = plain_v[i];
      req_key[128*i +: 128]   = key_v[i];
      req_dec[i]              = dec_v[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      plain_v[i] = {$urandom, $urandom, $urandom, $urandom};
      key_v[i]   = {$urandom, $urandom, $urandom, $urandom};
      dec_v[i]   = 1'($urandom);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_ready"}, 128'(req_ready), '0);
    check_eq({tag, "_resp_valid"}, 128'(resp_valid), '0);
    check_eq({tag, "_resp_data"}, resp_data, '0);
    check_eq({tag, "_resp_err"}, 128'(resp_err), '0);
    check_eq({tag, "_core_plain"}, core_plain, '0);
    check_eq({tag, "_core_key"}, core_key, '0);
    check_eq({tag, "_core_dec"}, 128'(core_dec), '0);
    check_eq({tag, "_core_start"}, 128'(core_start), '0);
    check_eq({tag, "_busy"}, 128'(busy), '0);
  endtask

  // One full job; entered and left at a negedge with the DUT idle.
  // d: cycle (after the start edge) on which finish is driven; d >= TMO means timeout.
  task automatic run_job(input logic [NR-1:0] valid, input int d, input int bp);
    int own, exp_k;
    logic [NR-1:0] oh;
    logic [127:0] exp_data, exp_p, exp_k128;
    logic exp_err, exp_d;
    req_valid = valid;
    drive_ops();
    #1;
    own = rr_pick(valid, last_g);
    oh = '0;
    oh[own] = 1'b1;
    exp_p = plain_v[own];
    exp_k128 = key_v[own];
    exp_d = dec_v[own];
    check_eq("grant", 128'(req_ready), 128'(oh));
    check_eq("idle_busy", 128'(busy), '0);
    @(posedge clk);
    last_g = own;
    @(negedge clk);
    req_valid = NR'($urandom);
    req_plain = {NR*4{$urandom}};
    check_eq("start", 128'(core_start), 128'(1));
    check_eq("op_plain", core_plain, exp_p);
    check_eq("op_key", core_key, exp_k128);
    check_eq("op_dec", 128'(core_dec), 128'(exp_d));
    check_eq("issue_ready", 128'(req_ready), '0);
    exp_err  = (d > TMO - 1);
    exp_k    = exp_err ? TMO : d + 1;
    exp_data = exp_err ? '0 : core_fn(exp_p, exp_k128, exp_d);
    for (int k = 1; k <= exp_k; k++) begin
      core_finish = (k - 1 == d);
      core_cipher = core_finish ? core_fn(core_plain, core_key, core_dec) : {4{$urandom}};
      @(negedge clk);
      core_finish = 1'b0;
      req_valid = NR'($urandom);
      check_eq("resp_valid_t", 128'(resp_valid), (k == exp_k) ? 128'(oh) : '0);
      if (k < exp_k) begin
        check_eq("wait_start", 128'(core_start), '0);
        check_eq("wait_plain", core_plain, exp_p);
        check_eq("wait_ready", 128'(req_ready), '0);
      end
    end
    check_eq("resp_data", resp_data, exp_data);
    check_eq("resp_err", 128'(resp_err), 128'(exp_err));
    // A finish arriving after the response is formed must be ignored.
    core_finish = (d == exp_k);
    core_cipher = {4{$urandom}};
    for (int b = 0; b < bp; b++) begin
      resp_ready = NR'($urandom) & ~oh;
      @(negedge clk);
      core_finish = 1'b0;
      req_valid = NR'($urandom);
      check_eq("bp_valid", 128'(resp_valid), 128'(oh));
      check_eq("bp_data", resp_data, exp_data);
      check_eq("bp_err", 128'(resp_err), 128'(exp_err));
      check_eq("bp_ready", 128'(req_ready), '0);
      check_eq("bp_start", 128'(core_start), '0);
    end
    resp_ready = oh | (NR'($urandom));
    @(negedge clk);
    core_finish = 1'b0;
    resp_ready = '0;
    check_eq("done_valid", 128'(resp_valid), '0);
    check_eq("done_busy", 128'(busy), '0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_dec = '0;
    req_plain = '0;
    req_key = '0;
    resp_ready = '0;
    core_finish = 1'b0;
    core_cipher = '0;
    last_g = NR - 1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // FIPS-197 encrypt on requester 0
    plain_v[0] = FIPS_P; key_v[0] = FIPS_K; dec_v[0] = 1'b0;
    plain_v[1] = '0;     key_v[1] = '0;     dec_v[1] = 1'b0;
    run_job(2'b01, 5, 0);

    // Decrypt round-trip on requester 1
    plain_v[1] = FIPS_C; key_v[1] = FIPS_K; dec_v[1] = 1'b1;
    run_job(2'b10, 7, 1);

    // Fairness with both requesters continuously valid
    for (int j = 0; j < 4; j++) begin
      rand_ops();
      run_job(2'b11, 2, 0);
    end

    // Long backpressure, timeout with late finish, finish on the timeout cycle
    rand_ops();
    run_job(2'b11, 3, 10);
    rand_ops();
    run_job(2'b01, TMO, 2);
    rand_ops();
    run_job(2'b10, TMO - 1, 1);

    // Reset in the middle of WAIT drops the job and restores priority to requester 0
    rand_ops();
    req_valid = 2'b01;
    drive_ops();
    #1;
    check_eq("mid_grant", 128'(req_ready), 128'(2'b01));
    @(negedge clk);
    check_eq("mid_start", 128'(core_start), 128'(1));
    req_valid = 2'b11;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    last_g = NR - 1;
    rand_ops();
    run_job(2'b11, 3, 0);

    // Randomized traffic
    for (int j = 0; j < 25; j++) begin
      int r, d;
      rand_ops();
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? TMO : (r == 1) ? TMO - 1 : int'($urandom_range(1, 8));
      run_job(NR'($urandom_range(1, 3)), d, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Round-robin scheduler that shares one iterative AES core (128-bit plain/key/cipher, start/finish/dec handshake) between NUM_REQ requesters.
- Accepts one job per grant, registers its operands, and pulses the core start. It then waits for finish, captures the cipher and returns it to the owning requester.
- Sits between the system-level request sources (e.g. SHA3 key-derivation path, host port) and the single AES core instance.

Parameters:
- NUM_REQ, 2, number of requesters (1..8)
- TIMEOUT, 64, max cycles waiting for core_finish before the job is aborted with error
- IDX_W, $clog2(NUM_REQ) (min 1), width of the grant index (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester job request
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high
- req_dec  in  NUM_REQ  1 = decrypt, 0 = encrypt
- req_plain  in  NUM_REQ*128  input block, requester i at [128*i +: 128]
- req_key  in  NUM_REQ*128  key, same packing
- resp_valid  out  NUM_REQ  one-hot result valid
- resp_ready  in  NUM_REQ  per-requester result accept
- resp_data  out  128  result block (shared bus, qualified by resp_valid)
- resp_err  out  1  result is a timeout abort
- core_plain  out  128  to core plain
- core_key  out  128  to core key
- core_dec  out  1  to core dec
- core_start  out  1  single-cycle start pulse
- core_finish  in  1  core done
- core_cipher  in  128  core result
- busy  out  1  state != IDLE

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, core_plain/core_key=0, core_dec=0, core_start=0, busy=0, state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), timer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Combinationally select the first requester with req_valid, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - Drive its req_ready high. No req_valid: all req_ready=0.
  - On handshake (valid & ready), register plain, key and dec into core_* and the index into owner; set last_grant=owner; go to ISSUE.
- ISSUE: core_start=1 for exactly this one cycle; timer cleared; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - core_finish=1: capture core_cipher into resp_data, resp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: resp_data=0, resp_err=1, go to RESP.
  - finish and timeout in the same cycle: finish wins.
- RESP:
  - resp_valid[owner]=1, other bits 0; resp_data/resp_err held stable until resp_ready[owner].
  - On that handshake go to IDLE; a new grant is possible the following cycle.
- Latency: handshake cycle N -> core_start at N+1 -> finish at cycle F -> resp_valid at F+1.
- core_finish outside WAIT is ignored. core_plain/key/dec stay stable from ISSUE through WAIT.
- req_valid is not required to stay high once ungranted; only the handshake cycle matters.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- resp_ready of non-owners ignored; req_ready all 0 outside IDLE.
- Reset mid-operation: return to reset values immediately; any in-flight job is dropped with no response.

Decomposition:
- Package aes_ctrl_pkg:
  - AES_W=128
  - state enum {S_IDLE, S_ISSUE, S_WAIT, S_RESP}, 2-bit encoding
- Sub-module rr_arbiter (combinational):
  - inputs req[NUM_REQ], last_grant
  - outputs grant one-hot, grant_idx, any

Test Plan:
- FIPS-197 encrypt: req_valid[0], key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff, dec=0 -> core_start one cycle after accept; resp_valid[0] one cycle after finish with resp_data 69c4e0d86a7b0430d8cdb78070b4c55a, resp_err=0.
- Decrypt round-trip: requester 1, dec=1, plain 69c4e0d86a7b0430d8cdb78070b4c55a, same key -> resp_valid[1], resp_data 00112233445566778899aabbccddeeff.
- Fairness: both requesters valid continuously for 4 jobs -> grant order 0,1,0,1; never two req_ready bits high.
- Backpressure: resp_ready[0] held 0 for 10 cycles -> resp_valid/resp_data stable; req_ready stays 0; no second core_start.
- Timeout: core model never asserts finish, TIMEOUT=64 -> resp_valid with resp_err=1 and resp_data=0 exactly 64 cycles after core_start; a late core_finish is ignored.
- Reset mid-WAIT: assert rst -> all outputs to reset values in the same cycle without a clock edge; after release, requester 0 wins the first grant.
